if_fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register; consumes its current PC and drives its write enable.
- Issues in-order requests to a variable-latency instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions with their PCs in a small queue and hands them to decode over valid/ready.
- Handles redirects (taken branch/jump) by clearing the queue and discarding in-flight responses.

---
 rtl/if_fetch_queue.sv | 92 +++++++++
 tb/tb_if_fetch_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: in-order instruction fetch with credit-limited requests, a PC pairing FIFO and redirect squashing
module if_fetch_queue #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk_i,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_i,
   output logic            pc_write_o,
   input  logic            flush_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            inst_valid_o,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] inst_pc_o,
   input  logic            inst_ready_i
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
   localparam logic [CW:0]   DEPTH_W = {1'b0, DEPTH_C};

   logic [CW-1:0]   cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d, ard_q, ard_d, awr_q, awr_d;
   logic [XLEN-1:0] ins_mem [DEPTH];
   logic [XLEN-1:0] ipc_mem [DEPTH];
   logic [XLEN-1:0] adr_mem [DEPTH];
   logic [CW:0]     used;
   logic            req, grant, keep, pop;

   // credit comes from registered occupancy only, so a pop frees a slot one cycle later
   assign used  = {1'b0, cnt_q} + {1'b0, out_q};
   assign req   = (used < DEPTH_W) & ~flush_i;
   assign grant = req & imem_gnt_i;
   assign keep  = imem_rvalid_i & (drop_q == '0) & ~flush_i;
   assign pop   = (cnt_q != '0) & inst_ready_i;

   assign imem_req_o   = rst_n & req;
   assign pc_write_o   = rst_n & (grant | flush_i);
   assign inst_valid_o = rst_n & (cnt_q != '0);
   assign imem_addr_o  = pc_i;
   assign inst_o       = ins_mem[head_q];
   assign inst_pc_o    = ipc_mem[head_q];

   // next state; a flush empties the queue and marks every still-in-flight request for dropping
   always_comb begin
      out_d  = out_q + CW'(grant) - CW'(imem_rvalid_i);
      drop_d = flush_i ? out_q - CW'(imem_rvalid_i) : drop_q - CW'(imem_rvalid_i && drop_q != '0);
      cnt_d  = flush_i ? '0 : cnt_q + CW'(keep) - CW'(pop);
      head_d = flush_i ? '0 : head_q + AW'(pop);
      tail_d = flush_i ? '0 : tail_q + AW'(keep);
      ard_d  = ard_q + AW'(imem_rvalid_i);
      awr_d  = awr_q + AW'(grant);
   end

   // counters and pointers
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         out_q  <= '0;
         drop_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         ard_q  <= '0;
         awr_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         drop_q <= drop_d;
         head_q <= head_d;
         tail_q <= tail_d;
         ard_q  <= ard_d;
         awr_q  <= awr_d;
      end
   end

   // storage is qualified by the counters, so it needs no reset
   always_ff @(posedge clk_i) begin
      if (grant) adr_mem[awr_q] <= pc_i;
      if (keep) begin
         ins_mem[tail_q] <= imem_rdata_i;
         ipc_mem[tail_q] <= adr_mem[ard_q];
      end
   end

   // a kept response always finds room, and every response answers an earlier request
   assert property (@(posedge clk_i) disable iff (!rst_n) keep |-> (cnt_q != DEPTH_C));
   assert property (@(posedge clk_i) disable iff (!rst_n) imem_rvalid_i |-> (out_q != '0));
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed scenarios against a latency-1 memory and a PC register model
module tb_if_fetch_queue;
   localparam int XLEN = 32;
   logic            clk_i = 1'b0;
   logic            rst_n = 1'b0;
   logic [XLEN-1:0] pc_i;
   logic            pc_write_o;
   logic            flush_i = 1'b0;
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i = 1'b0;
   logic            imem_rvalid_i = 1'b0;
   logic [XLEN-1:0] imem_rdata_i = '0;
   logic            inst_valid_o;
   logic [XLEN-1:0] inst_o;
   logic [XLEN-1:0] inst_pc_o;
   logic            inst_ready_i = 1'b0;
   logic [XLEN-1:0] tgt = '0;
   logic            rv_en = 1'b0;
   logic [XLEN-1:0] pend [$];
   int checks = 0;
   int errors = 0;

   if_fetch_queue #(.DEPTH(2), .XLEN(XLEN)) dut (
      .clk_i(clk_i), .rst_n(rst_n), .pc_i(pc_i), .pc_write_o(pc_write_o), .flush_i(flush_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o),
      .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_ready_i(inst_ready_i)
   );

   always #5 clk_i = ~clk_i;

   // PC register: redirect target on flush, otherwise sequential advance
   always @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) pc_i <= '0;
      else if (pc_write_o) pc_i <= flush_i ? tgt : pc_i + 32'd4;
   end

   function automatic logic [XLEN-1:0] ins(input logic [XLEN-1:0] a);
      return {a[15:0], 16'h0013};
   endfunction

   // one clock: record handshakes at the negedge, then present the next in-order response
   task automatic cyc();
      @(negedge clk_i);
      if (imem_rvalid_i && pend.size() > 0) pend.delete(0);
      if (imem_req_o && imem_gnt_i) pend.push_back(imem_addr_o);
      @(posedge clk_i);
      #1;
      imem_rvalid_i = rv_en && rst_n && pend.size() > 0;
      imem_rdata_i  = imem_rvalid_i ? ins(pend[0]) : '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; flush_i = 1'b0; imem_gnt_i = 1'b0; inst_ready_i = 1'b0; rv_en = 1'b0;
      imem_rvalid_i = 1'b0; pend.delete();
      cyc(); cyc();
   endtask

   task automatic start(input logic g, input logic r, input logic rdy);
      do_reset();
      imem_gnt_i = g; rv_en = r; inst_ready_i = rdy; rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      imem_gnt_i = 1'b1; flush_i = 1'b1; inst_ready_i = 1'b1;
      #1;
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req_o); end
      checks++; if (pc_write_o !== 1'b0) begin errors++; $display("FAIL rst_pcw got %b exp 0", pc_write_o); end
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid_o); end
      flush_i = 1'b0;
   endtask

   task automatic test_fetch();
      logic [XLEN-1:0] exp;
      int pops;
      start(1'b1, 1'b1, 1'b1);
      checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL f_c0_req got %b exp 1", imem_req_o); end
      checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL f_c0_addr got %h exp 0", imem_addr_o); end
      checks++; if (pc_write_o !== 1'b1) begin errors++; $display("FAIL f_c0_pcw got %b exp 1", pc_write_o); end
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL f_c0_valid got %b exp 0", inst_valid_o); end
      cyc(); #1;
      checks++; if (imem_addr_o !== 32'h4) begin errors++; $display("FAIL f_c1_addr got %h exp 4", imem_addr_o); end
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL f_c1_valid got %b exp 0", inst_valid_o); end
      cyc(); #1;
      checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL f_c2_valid got %b exp 1", inst_valid_o); end
      checks++; if (inst_o !== 32'h00000013) begin errors++; $display("FAIL f_c2_inst got %h exp 00000013", inst_o); end
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL f_c2_req got %b exp 0", imem_req_o); end
      exp = '0; pops = 0;
      for (int i = 0; i < 12; i++) begin
         if (inst_valid_o) begin
            checks++; if (inst_pc_o !== exp) begin errors++; $display("FAIL f_stream_pc got %h exp %h", inst_pc_o, exp); end
            checks++; if (inst_o !== ins(exp)) begin errors++; $display("FAIL f_stream_inst got %h exp %h", inst_o, ins(exp)); end
            exp = exp + 32'd4; pops++;
         end
         cyc(); #1;
      end
      checks++; if (pops != 8) begin errors++; $display("FAIL f_pop_count got %0d exp 8", pops); end
   endtask

   task automatic test_backpressure();
      start(1'b1, 1'b1, 1'b0);
      checks++; if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin errors++; $display("FAIL bp_c0 req %b addr %h exp 1 0", imem_req_o, imem_addr_o); end
      cyc(); #1;
      checks++; if (imem_addr_o !== 32'h4 || imem_req_o !== 1'b1) begin errors++; $display("FAIL bp_c1 req %b addr %h exp 1 4", imem_req_o, imem_addr_o); end
      cyc(); #1;
      checks++; if (imem_req_o !== 1'b0 || pc_write_o !== 1'b0) begin errors++; $display("FAIL bp_c2 req %b pcw %b exp 0 0", imem_req_o, pc_write_o); end
      cyc(); #1;
      checks++; if (imem_req_o !== 1'b0 || pc_write_o !== 1'b0) begin errors++; $display("FAIL bp_full req %b pcw %b exp 0 0", imem_req_o, pc_write_o); end
      checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL bp_full_head valid %b pc %h exp 1 0", inst_valid_o, inst_pc_o); end
      cyc(); inst_ready_i = 1'b1; #1;
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_pop_req got %b exp 0", imem_req_o); end
      checks++; if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL bp_pop0_pc got %h exp 0", inst_pc_o); end
      cyc(); #1;
      checks++; if (inst_pc_o !== 32'h4 || inst_o !== 32'h00040013) begin errors++; $display("FAIL bp_pop1 pc %h inst %h exp 4 00040013", inst_pc_o, inst_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++; $display("FAIL bp_resume req %b addr %h exp 1 8", imem_req_o, imem_addr_o); end
      cyc(); #1;
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", inst_valid_o); end
   endtask

   task automatic test_gnt_hold();
      start(1'b1, 1'b1, 1'b1);
      cyc(); #1;
      cyc(); imem_gnt_i = 1'b0; #1;
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL gh_c2_req got %b exp 0", imem_req_o); end
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || pc_write_o !== 1'b0) begin errors++; $display("FAIL gh_hold%0d req %b addr %h pcw %b exp 1 8 0", i, imem_req_o, imem_addr_o, pc_write_o); end
      end
      cyc(); imem_gnt_i = 1'b1; #1;
      checks++; if (pc_write_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++; $display("FAIL gh_grant pcw %b addr %h exp 1 8", pc_write_o, imem_addr_o); end
      cyc(); #1;
      checks++; if (imem_addr_o !== 32'hc) begin errors++; $display("FAIL gh_next_addr got %h exp c", imem_addr_o); end
      cyc(); #1;
      checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h8 || inst_o !== 32'h00080013) begin errors++; $display("FAIL gh_head valid %b pc %h inst %h exp 1 8 00080013", inst_valid_o, inst_pc_o, inst_o); end
   endtask

   task automatic test_flush_drain();
      start(1'b1, 1'b0, 1'b1);
      cyc(); #1;
      cyc(); flush_i = 1'b1; tgt = 32'h100; rv_en = 1'b1; #1;
      checks++; if (imem_req_o !== 1'b0 || pc_write_o !== 1'b1) begin errors++; $display("FAIL fd_flush req %b pcw %b exp 0 1", imem_req_o, pc_write_o); end
      cyc(); flush_i = 1'b0; #1;
      checks++; if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL fd_drop1 valid %b req %b exp 0 0", inst_valid_o, imem_req_o); end
      cyc(); #1;
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fd_drop2_valid got %b exp 0", inst_valid_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL fd_target req %b addr %h exp 1 100", imem_req_o, imem_addr_o); end
      cyc(); #1;
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fd_c5_valid got %b exp 0", inst_valid_o); end
      cyc(); #1;
      checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h100 || inst_o !== 32'h01000013) begin errors++; $display("FAIL fd_target_head valid %b pc %h inst %h exp 1 100 01000013", inst_valid_o, inst_pc_o, inst_o); end
   endtask

   task automatic test_flush_rvalid();
      start(1'b1, 1'b1, 1'b0);
      cyc(); #1;
      cyc(); flush_i = 1'b1; tgt = 32'h200; inst_ready_i = 1'b1; #1;
      checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL fr_head valid %b pc %h exp 1 0", inst_valid_o, inst_pc_o); end
      checks++; if (imem_req_o !== 1'b0 || pc_write_o !== 1'b1) begin errors++; $display("FAIL fr_flush req %b pcw %b exp 0 1", imem_req_o, pc_write_o); end
      cyc(); flush_i = 1'b0; #1;
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fr_empty got %b exp 0", inst_valid_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++; $display("FAIL fr_target req %b addr %h exp 1 200", imem_req_o, imem_addr_o); end
      cyc(); #1;
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fr_discard got %b exp 0", inst_valid_o); end
      cyc(); #1;
      checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h200 || inst_o !== 32'h02000013) begin errors++; $display("FAIL fr_target_head valid %b pc %h inst %h exp 1 200 02000013", inst_valid_o, inst_pc_o, inst_o); end
   endtask

   task automatic test_async_reset();
      start(1'b1, 1'b1, 1'b0);
      cyc(); imem_gnt_i = 1'b0; #1;
      cyc(); imem_gnt_i = 1'b1; #1;
      checks++; if (inst_valid_o !== 1'b1 || imem_req_o !== 1'b1 || pc_write_o !== 1'b1) begin errors++; $display("FAIL ar_pre valid %b req %b pcw %b exp 1 1 1", inst_valid_o, imem_req_o, pc_write_o); end
      rst_n = 1'b0;
      #1;
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", inst_valid_o); end
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL ar_req got %b exp 0", imem_req_o); end
      checks++; if (pc_write_o !== 1'b0) begin errors++; $display("FAIL ar_pcw got %b exp 0", pc_write_o); end
      pend.delete(); imem_rvalid_i = 1'b0;
      cyc(); cyc();
      inst_ready_i = 1'b1; rst_n = 1'b1;
      #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || pc_write_o !== 1'b1) begin errors++; $display("FAIL ar_c0 req %b addr %h pcw %b exp 1 0 1", imem_req_o, imem_addr_o, pc_write_o); end
      cyc(); #1;
      checks++; if (imem_addr_o !== 32'h4 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL ar_c1 addr %h valid %b exp 4 0", imem_addr_o, inst_valid_o); end
      cyc(); #1;
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00000013 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL ar_c2 valid %b inst %h pc %h exp 1 00000013 0", inst_valid_o, inst_o, inst_pc_o); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_backpressure();
      test_gnt_hold();
      test_flush_drain();
      test_flush_rvalid();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
